// File: rtl/csla_pkg.sv
// Shared constants and arithmetic helpers for the pipelined carry-select adder.
package csla_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BLK   = 8;
  // Largest block the ripple helper can handle.
  localparam int MAX_BLK   = 64;

  // Ripple result for one block: bit n is the carry-out, bits [n-1:0] the sum.
  typedef logic [MAX_BLK:0] blk_res_t;

  // Propagate/generate ripple over the low n bits of a and b.
  function automatic blk_res_t ripple_blk(input logic [MAX_BLK-1:0] a,
                                          input logic [MAX_BLK-1:0] b,
                                          input logic               cin,
                                          input int                 n);
    blk_res_t r;
    logic     c;
    logic     p;
    logic     g;
    r = '0;
    c = cin;
    for (int i = 0; i < MAX_BLK; i++) begin
      if (i < n) begin
        p    = a[i] ^ b[i];
        g    = a[i] & b[i];
        r[i] = p ^ c;
        c    = g | (p & c);
      end
    end
    // Bits at or above n leave c untouched, so c is the carry out of bit n-1.
    for (int i = 0; i <= MAX_BLK; i++) begin
      if (i == n) r[i] = c;
    end
    return r;
  endfunction

  // Signed overflow: both addends share a sign and the sum's sign differs.
  function automatic logic ovf_chk(input logic a_msb,
                                   input logic b_msb,
                                   input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/csla_stage.sv
// One carry-select block: both carry candidates are formed from the held
// operand slices, and the carry coming from the previous stage picks one.
module csla_stage
  import csla_pkg::*;
#(
  parameter int BLK = DEF_BLK
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           adv,
  input  logic           in_valid,
  input  logic [BLK-1:0] in_a,
  input  logic [BLK-1:0] in_b,
  input  logic           in_cin,
  output logic [BLK-1:0] out_sum,
  output logic           out_cout,
  output logic           out_valid
);

  logic [BLK:0] cand0;
  logic [BLK:0] cand1;
  logic [BLK:0] pick;

  // Precompute the block for carry-in 0 and 1, then select on the incoming carry.
  always_comb begin
    cand0 = (BLK+1)'(ripple_blk(MAX_BLK'(in_a), MAX_BLK'(in_b), 1'b0, BLK));
    cand1 = (BLK+1)'(ripple_blk(MAX_BLK'(in_a), MAX_BLK'(in_b), 1'b1, BLK));
    pick  = in_cin ? cand1 : cand0;
  end

  // Stage register: valid follows the pipeline; data loads only for real beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else if (adv) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_sum  <= pick[BLK-1:0];
        out_cout <= pick[BLK];
      end
    end
  end

endmodule

// File: rtl/csla_pipe.sv
// Pipelined carry-select adder/subtractor: stage k resolves block k, so the
// latency is NBLK cycles and one result can leave every cycle.
module csla_pipe
  import csla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLK   = DEF_BLK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NBLK = (BLK >= 1) ? WIDTH / BLK : 1;

  if (BLK < 1 || BLK > MAX_BLK || (WIDTH % BLK) != 0) begin : g_param_check
    $error("csla_pipe: WIDTH must be a positive multiple of BLK, with 1 <= BLK <= MAX_BLK");
  end

  logic             adv;
  logic [WIDTH-1:0] beff;
  logic             c0;

  // Handshake: a beat moves on a rising edge where valid && ready on that side.
  // The whole pipe advances together (adv) whenever the output register is
  // empty or being drained; otherwise every stage, bubbles included, holds.
  // in_ready equals adv and depends only on out_ready and the last valid bit.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction is A + ~B + 1; the carry-in port is ignored in that mode.
  assign beff = in_sub ? ~in_b : in_b;
  assign c0   = in_sub | in_cin;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    // Operand bits still to be added when the beat enters stage k.
    localparam int SRCW = WIDTH - k * BLK;
    localparam int LOW  = k * BLK;

    logic [SRCW-1:0]    a_src;
    logic [SRCW-1:0]    b_src;
    logic               cin_src;
    logic               v_src;
    logic               amsb_src;
    logic               bmsb_src;
    logic [BLK-1:0]     s_k;
    logic               c_k;
    logic               v_k;
    logic               amsb_q;
    logic               bmsb_q;
    logic [LOW+BLK-1:0] psum;

    if (k == 0) begin : g_head
      assign a_src    = in_a;
      assign b_src    = beff;
      assign cin_src  = c0;
      assign v_src    = in_valid;
      assign amsb_src = in_a[WIDTH-1];
      assign bmsb_src = beff[WIDTH-1];
      assign psum     = s_k;
    end else begin : g_tail
      logic [LOW-1:0] lo_q;

      assign a_src    = g_stage[k-1].g_fwd.a_q;
      assign b_src    = g_stage[k-1].g_fwd.b_q;
      assign cin_src  = g_stage[k-1].c_k;
      assign v_src    = g_stage[k-1].v_k;
      assign amsb_src = g_stage[k-1].amsb_q;
      assign bmsb_src = g_stage[k-1].bmsb_q;
      assign psum     = {s_k, lo_q};

      // Partial sum of the blocks already resolved upstream travels with the beat.
      always_ff @(posedge clk) begin
        if (rst) begin
          lo_q <= '0;
        end else if (adv && v_src) begin
          lo_q <= g_stage[k-1].psum;
        end
      end
    end

    if (k < NBLK - 1) begin : g_fwd
      logic [SRCW-BLK-1:0] a_q;
      logic [SRCW-BLK-1:0] b_q;

      // Skew register: the unprocessed upper blocks wait for their stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && v_src) begin
          a_q <= a_src[SRCW-1:BLK];
          b_q <= b_src[SRCW-1:BLK];
        end
      end
    end

    // Operand sign bits ride along so the last stage can flag overflow.
    always_ff @(posedge clk) begin
      if (rst) begin
        amsb_q <= 1'b0;
        bmsb_q <= 1'b0;
      end else if (adv && v_src) begin
        amsb_q <= amsb_src;
        bmsb_q <= bmsb_src;
      end
    end

    csla_stage #(
      .BLK (BLK)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .adv       (adv),
      .in_valid  (v_src),
      .in_a      (a_src[BLK-1:0]),
      .in_b      (b_src[BLK-1:0]),
      .in_cin    (cin_src),
      .out_sum   (s_k),
      .out_cout  (c_k),
      .out_valid (v_k)
    );
  end

  assign out_valid = g_stage[NBLK-1].v_k;
  assign out_sum   = g_stage[NBLK-1].psum;
  assign out_cout  = g_stage[NBLK-1].c_k;
  assign out_ovf   = ovf_chk(g_stage[NBLK-1].amsb_q, g_stage[NBLK-1].bmsb_q,
                             out_sum[WIDTH-1]);

endmodule

// File: tb/tb_csla_pipe.sv
// Directed bench for csla_pipe (WIDTH=32, BLK=8, latency 4) with a short
// random tail checked against an A + Beff + c0 reference.
module tb_csla_pipe;

  localparam int W   = 32;
  localparam int LAT = 4;
  localparam int NRAND = 400;

  // clock / reset
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic done;

  // {ovf, cout, sum} entries
  logic [W+1:0] got_q[$];
  int           got_cyc_q[$];
  int           acc_q[$];
  logic [W+1:0] exp_q[$];

  csla_pipe #(
    .WIDTH (32),
    .BLK   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // capture every output handshake, with the cycle it happened in
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_q.push_back({out_ovf, out_cout, out_sum});
      got_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: present one beat, hold until accepted, then drop in_valid
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic sb);
    int           t;
    logic [W-1:0] be;
    logic [W:0]   full;
    t = 0;
    in_a = a; in_b = b; in_cin = ci; in_sub = sb; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("accept", in_ready, 1);
    acc_q.push_back(cyc);
    be   = sb ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + (W+1)'(sb | ci);
    exp_q.push_back({(a[W-1] == be[W-1]) && (full[W-1] != a[W-1]), full[W], full[W-1:0]});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // scoreboard pop: compare the oldest output beat with the expected fields
  task automatic check_beat(input string tag, input logic [W-1:0] s,
                            input logic co, input logic ov, input int lat);
    int           t;
    int           gc;
    int           ac;
    logic [W+1:0] g;
    logic [W+1:0] dummy;
    t = 0;
    while (got_q.size() == 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({tag, "_arrive"}, (got_q.size() > 0), 1);
    if (got_q.size() > 0) begin
      g  = got_q.pop_front();
      gc = got_cyc_q.pop_front();
      ac = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
      if (exp_q.size() > 0) dummy = exp_q.pop_front();
      chk({tag, "_sum"},  g[W-1:0], s);
      chk({tag, "_cout"}, g[W],     co);
      chk({tag, "_ovf"},  g[W+1],   ov);
      if (lat > 0) chk({tag, "_lat"}, gc - ac, lat);
    end
  endtask

  initial begin
    logic [W+1:0] e;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1; done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_sum",   out_sum,   0);
    chk("rst_cout",  out_cout,  0);
    chk("rst_ovf",   out_ovf,   0);
    chk("rst_ready", in_ready,  1);
    @(posedge clk);
    #1;

    // full carry chain through every block
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check_beat("chain", 32'h0000_0000, 1'b1, 1'b0, LAT);

    // subtract: signed overflow, then a borrow
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    check_beat("sub_ovf",    32'h7FFF_FFFF, 1'b1, 1'b1, LAT);
    check_beat("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, LAT);

    // streaming: 8 back-to-back beats, each must keep the 4-cycle latency
    for (int i = 0; i < 8; i++) send(W'(i), W'(i) << 24, i[0], 1'b0);
    for (int i = 0; i < 8; i++)
      check_beat("stream", (W'(i) << 24) + W'(i) + W'(i & 1), 1'b0, 1'b0, LAT);

    // backpressure: stall with 4 beats in flight
    send(32'h0000_0010, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_0020, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_0030, 32'h0000_0001, 1'b0, 1'b0);
    out_ready = 1'b0;
    send(32'h9000_0000, 32'h9000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", in_ready,  0);
      chk("stall_valid", out_valid, 1);
      chk("stall_sum",   out_sum,   32'h0000_0011);
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    check_beat("bp0", 32'h0000_0011, 1'b0, 1'b0, 0);
    check_beat("bp1", 32'h0000_0021, 1'b0, 1'b0, 0);
    check_beat("bp2", 32'h0000_0031, 1'b0, 1'b0, 0);
    check_beat("bp3", 32'h2000_0000, 1'b1, 1'b1, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("bp_no_dup", got_q.size(), 0);

    // reset with 3 beats in flight
    send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0);
    send(32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    acc_q.delete();
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum",   out_sum,   0);
    chk("mid_rst_cout",  out_cout,  0);
    chk("mid_rst_ovf",   out_ovf,   0);
    chk("mid_rst_ready", in_ready,  1);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_stale", got_q.size(), 0);

    // cin ignored in subtract, A==B, add with cin, positive overflow
    send(32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1);
    send(32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1);
    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    check_beat("sub_cin",  32'h0000_000D, 1'b1, 1'b0, LAT);
    check_beat("sub_eq",   32'h0000_0000, 1'b1, 1'b0, LAT);
    check_beat("add_cin",  32'h2345_678A, 1'b0, 1'b0, LAT);
    check_beat("add_povf", 32'h8000_0000, 1'b0, 1'b1, LAT);

    // random valid/ready with sub/cin, against the reference queue
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          logic [W-1:0] ra;
          logic [W-1:0] rb;
          repeat ($urandom_range(0, 2)) @(posedge clk);
          if (!in_valid) #1;
          ra = $urandom();
          rb = ($urandom_range(0, 3) == 0) ? ~ra : $urandom();
          send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          if (!done) out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < NRAND; i++) begin
      if (exp_q.size() == 0) break;
      e = exp_q[0];
      check_beat("rand", e[W-1:0], e[W], e[W+1], 0);
    end
    repeat (10) @(posedge clk);
    #1;
    chk("rand_no_extra", got_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
